// File: rtl/iobus_master.sv
// PDP-6 IO bus initiator: sequences one DATAO/CONO/DATAI/CONI transfer at a
// time with timed clear/set/read strobes, generates power-on and IO reset,
// and priority-encodes the seven PI request lines.
//
// state | meaning
// PWR   | power-on hold: poweron low, iob_reset high
// RST   | IO bus reset pulse
// IDLE  | ready for a command or a pending reset
// SETUP | ios/iob_out settling before the first strobe
// CLR   | datao_clear / cono_clear high
// GAP   | all strobes low between clear and set
// SET   | datao_set / cono_set high
// READ  | iob_fm_datai / iob_fm_status high, bus sampled on last cycle
// HOLD  | ios/iob_out held after the last strobe
module iobus_master #(
    parameter int SETUP_CYC = 2,
    parameter int CLR_CYC   = 4,
    parameter int GAP_CYC   = 2,
    parameter int SET_CYC   = 4,
    parameter int RD_CYC    = 4,
    parameter int HOLD_CYC  = 2,
    parameter int RST_CYC   = 8,
    parameter int PWR_CYC   = 16   // must be >= 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [6:0]  cmd_dev,
    input  logic [35:0] cmd_data,
    output logic        rsp_valid,
    output logic [35:0] rsp_data,
    input  logic        io_reset_req,
    input  logic [6:0]  pi_mask,
    output logic [2:0]  pi_level,
    output logic [6:0]  iobus_ios,
    output logic [35:0] iobus_iob_out,
    input  logic [35:0] iobus_iob_in,
    input  logic [6:0]  iobus_pi_req,
    output logic        iobus_datao_clear,
    output logic        iobus_datao_set,
    output logic        iobus_cono_clear,
    output logic        iobus_cono_set,
    output logic        iobus_iob_fm_datai,
    output logic        iobus_iob_fm_status,
    output logic        iobus_iob_reset,
    output logic        iobus_iob_poweron
);

    typedef enum logic [3:0] {
        S_PWR, S_RST, S_IDLE, S_SETUP, S_CLR, S_GAP, S_SET, S_READ, S_HOLD
    } state_t;

    state_t      state, state_n;
    logic [7:0]  cnt, cnt_n;
    logic [1:0]  op;
    logic        pend;
    logic        accept, clear_io, sample, pend_clr, last;
    logic [6:0]  pi_sync1, pi_sync2, pi_masked;

    // Next-state and counter reload; a timed state ends on the cycle its
    // counter reads 1. PWR leaves reset with the counter at 0, so its first
    // cycle loads PWR_CYC-1 to make the total exactly PWR_CYC.
    always_comb begin
        state_n  = state;
        cnt_n    = (cnt == 8'd0) ? 8'd0 : cnt - 8'd1;
        accept   = 1'b0;
        clear_io = 1'b0;
        sample   = 1'b0;
        pend_clr = 1'b0;
        last     = (cnt == 8'd1);
        case (state)
            S_PWR: begin
                if (cnt == 8'd0) begin
                    cnt_n = 8'(PWR_CYC - 1);
                end else if (last) begin
                    state_n  = S_RST;
                    cnt_n    = 8'(RST_CYC);
                    pend_clr = 1'b1;
                end
            end
            S_RST: if (last) state_n = S_IDLE;
            S_IDLE: begin
                if (pend) begin
                    state_n  = S_RST;
                    cnt_n    = 8'(RST_CYC);
                    pend_clr = 1'b1;
                end else if (cmd_valid) begin
                    accept  = 1'b1;
                    state_n = S_SETUP;
                    cnt_n   = 8'(SETUP_CYC);
                end
            end
            S_SETUP: begin
                if (last) begin
                    state_n = op[1] ? S_READ : S_CLR;
                    cnt_n   = op[1] ? 8'(RD_CYC) : 8'(CLR_CYC);
                end
            end
            S_CLR: begin
                if (last) begin
                    state_n = S_GAP;
                    cnt_n   = 8'(GAP_CYC);
                end
            end
            S_GAP: begin
                if (last) begin
                    state_n = S_SET;
                    cnt_n   = 8'(SET_CYC);
                end
            end
            S_SET, S_READ: begin
                if (last) begin
                    sample  = (state == S_READ);
                    state_n = S_HOLD;
                    cnt_n   = 8'(HOLD_CYC);
                end
            end
            S_HOLD: begin
                if (last) begin
                    clear_io = 1'b1;
                    if (pend) begin
                        state_n  = S_RST;
                        cnt_n    = 8'(RST_CYC);
                        pend_clr = 1'b1;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            default: begin
                state_n = S_PWR;
                cnt_n   = 8'd0;
            end
        endcase
    end

    // State, counter and the sticky reset request (not re-armed during RST).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_PWR;
            cnt   <= 8'd0;
            pend  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (pend_clr)
                pend <= 1'b0;
            else if (io_reset_req && state != S_RST)
                pend <= 1'b1;
        end
    end

    // Command latch: op, device select and output word held for the transfer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op            <= 2'd0;
            iobus_ios     <= 7'd0;
            iobus_iob_out <= 36'd0;
        end else if (accept) begin
            op            <= cmd_op;
            iobus_ios     <= cmd_dev;
            iobus_iob_out <= cmd_data;
        end else if (clear_io) begin
            iobus_ios     <= 7'd0;
            iobus_iob_out <= 36'd0;
        end
    end

    // Read capture on the last READ cycle; rsp_data holds until the next read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid <= 1'b0;
            rsp_data  <= 36'd0;
        end else begin
            rsp_valid <= sample;
            if (sample)
                rsp_data <= iobus_iob_in;
        end
    end

    // Two-flop synchronizer for the asynchronous PI request lines.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pi_sync1 <= 7'd0;
            pi_sync2 <= 7'd0;
        end else begin
            pi_sync1 <= iobus_pi_req;
            pi_sync2 <= pi_sync1;
        end
    end

    // Priority encode: bit 6 is channel 1 (highest priority), bit 0 channel 7.
    always_comb begin
        pi_masked = pi_sync2 & pi_mask;
        pi_level  = 3'd0;
        for (int k = 7; k >= 1; k--) begin
            if (pi_masked[7 - k])
                pi_level = 3'(k);
        end
    end

    // Strobes decode directly from registered state so they drop with reset.
    always_comb begin
        cmd_ready           = (state == S_IDLE) && !pend;
        iobus_datao_clear   = (state == S_CLR)  && (op == 2'd0);
        iobus_cono_clear    = (state == S_CLR)  && (op == 2'd1);
        iobus_datao_set     = (state == S_SET)  && (op == 2'd0);
        iobus_cono_set      = (state == S_SET)  && (op == 2'd1);
        iobus_iob_fm_datai  = (state == S_READ) && (op == 2'd2);
        iobus_iob_fm_status = (state == S_READ) && (op == 2'd3);
        iobus_iob_reset     = (state == S_PWR)  || (state == S_RST);
        iobus_iob_poweron   = (state != S_PWR);
    end

endmodule

// File: tb/tb_iobus_master.sv
// Directed bench for iobus_master with a read-response scoreboard and a
// simple responder returning fixed words while the read strobes are high.
module tb_iobus_master;

    localparam logic [35:0] STATUS_WORD = 36'o1257;
    localparam logic [35:0] DATAI_WORD  = 36'o123456701234;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_op;
    logic [6:0]  cmd_dev;
    logic [35:0] cmd_data;
    logic        rsp_valid;
    logic [35:0] rsp_data;
    logic        io_reset_req;
    logic [6:0]  pi_mask;
    logic [2:0]  pi_level;
    logic [6:0]  ios;
    logic [35:0] iob_out, iob_in;
    logic [6:0]  pi_req;
    logic        datao_clear, datao_set, cono_clear, cono_set;
    logic        fm_datai, fm_status, iob_reset, poweron;
    logic [7:0]  strb;

    int n_checks = 0;
    int n_errors = 0;
    logic [35:0] exp_q[$];

    iobus_master dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_dev(cmd_dev), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .io_reset_req(io_reset_req), .pi_mask(pi_mask), .pi_level(pi_level),
        .iobus_ios(ios), .iobus_iob_out(iob_out), .iobus_iob_in(iob_in),
        .iobus_pi_req(pi_req),
        .iobus_datao_clear(datao_clear), .iobus_datao_set(datao_set),
        .iobus_cono_clear(cono_clear), .iobus_cono_set(cono_set),
        .iobus_iob_fm_datai(fm_datai), .iobus_iob_fm_status(fm_status),
        .iobus_iob_reset(iob_reset), .iobus_iob_poweron(poweron)
    );

    always #5 clk = ~clk;

    assign strb = {datao_clear, datao_set, cono_clear, cono_set,
                   fm_datai, fm_status, iob_reset, poweron};

    // Responder model: drives a word only while a read strobe is high.
    always_comb begin
        iob_in = 36'd0;
        if (fm_status) iob_in = STATUS_WORD;
        else if (fm_datai) iob_in = DATAI_WORD;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Releases reset and follows the power-on / IO reset sequence to ready.
    task automatic power_seq();
        @(negedge clk);
        reset = 1'b1;
        #1;
        for (int c = 1; c <= 25; c++) begin
            check("pwr_poweron", 64'(poweron), 64'(c > 16));
            check("pwr_iob_reset", 64'(iob_reset), 64'(c <= 24));
            check("pwr_cmd_ready", 64'(cmd_ready), 64'(c >= 25));
            check("pwr_other_strobes", 64'(strb[7:2]), 64'd0);
            @(posedge clk); #1;
        end
    endtask

    // Issues one command and checks every output on every cycle of it.
    task automatic run_cmd(input logic [1:0] op, input logic [6:0] dev,
                           input logic [35:0] data, input bit rst_mid);
        int t, n_busy, n_last, n_rdy;
        logic [7:0]  es;
        logic [35:0] want;
        t = 0;
        while (cmd_ready !== 1'b1 && t < 100) begin
            @(posedge clk); #1; t++;
        end
        check("ready_before_cmd", 64'(cmd_ready), 64'd1);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_dev = dev; cmd_data = data;
        if (op[1]) exp_q.push_back(op[0] ? STATUS_WORD : DATAI_WORD);
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_dev = 7'h7f; cmd_data = '1;
        n_busy = op[1] ? 8 : 14;
        n_rdy  = n_busy + (rst_mid ? 8 : 0);
        n_last = n_rdy + 2;
        for (int c = 1; c <= n_last; c++) begin
            es = 8'b0000_0001;
            if (c >= 3 && c <= 6) begin
                case (op)
                    2'd0: es[7] = 1'b1;
                    2'd1: es[5] = 1'b1;
                    2'd2: es[3] = 1'b1;
                    default: es[2] = 1'b1;
                endcase
            end
            if (!op[1] && c >= 9 && c <= 12) begin
                if (op[0]) es[4] = 1'b1;
                else es[6] = 1'b1;
            end
            if (rst_mid && c > n_busy && c <= n_busy + 8) es[1] = 1'b1;
            check("strobes", 64'(strb), 64'(es));
            check("ios", 64'(ios), (c <= n_busy) ? 64'(dev) : 64'd0);
            check("iob_out", 64'(iob_out), (c <= n_busy) ? 64'(data) : 64'd0);
            check("cmd_ready", 64'(cmd_ready), 64'(c > n_rdy));
            check("rsp_valid", 64'(rsp_valid), 64'(op[1] && c == 7));
            if (rsp_valid === 1'b1) begin
                check("rsp_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    want = exp_q.pop_front();
                    check("rsp_data", 64'(rsp_data), 64'(want));
                end
            end
            if (rst_mid && c == 4) io_reset_req = 1'b1;
            if (rst_mid && c == 5) io_reset_req = 1'b0;
            if (rst_mid && c == n_busy + 3) io_reset_req = 1'b1;
            if (rst_mid && c == n_busy + 4) io_reset_req = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    // Global time bound so the run always ends.
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not reach its summary");
        $fatal(1, "timeout");
    end

    // Directed sequence.
    initial begin
        reset = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_dev = 7'd0;
        cmd_data = 36'd0; io_reset_req = 1'b0; pi_mask = 7'd0; pi_req = 7'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_strobes", 64'(strb), 64'b0000_0010);
        check("rst_ios", 64'(ios), 64'd0);
        check("rst_iob_out", 64'(iob_out), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_data", 64'(rsp_data), 64'd0);
        check("rst_pi_level", 64'(pi_level), 64'd0);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);

        power_seq();

        run_cmd(2'd0, 7'b0010100, 36'o101, 1'b0);
        run_cmd(2'd3, 7'b0010100, 36'o0, 1'b0);
        run_cmd(2'd2, 7'o11, 36'o777, 1'b0);
        run_cmd(2'd1, 7'o177, 36'o777777777777, 1'b1);
        check("rsp_data_held", 64'(rsp_data), 64'(DATAI_WORD));

        pi_mask = 7'b1111111;
        pi_req  = 7'b0011000;
        @(posedge clk); #1;
        check("pi_latency_1cyc", 64'(pi_level), 64'd0);
        @(posedge clk); #1;
        check("pi_ch3", 64'(pi_level), 64'd3);
        pi_mask = 7'b1101111;
        repeat (2) @(posedge clk);
        #1;
        check("pi_ch3_masked", 64'(pi_level), 64'd4);
        pi_mask = 7'b0000000;
        repeat (2) @(posedge clk);
        #1;
        check("pi_mask_zero", 64'(pi_level), 64'd0);
        pi_mask = 7'b1111111;
        pi_req  = 7'b0000001;
        repeat (2) @(posedge clk);
        #1;
        check("pi_ch7", 64'(pi_level), 64'd7);
        pi_req  = 7'b1111111;
        repeat (2) @(posedge clk);
        #1;
        check("pi_all", 64'(pi_level), 64'd1);
        pi_req  = 7'b0000000;

        // Asynchronous reset in the middle of a DATAO set phase.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_dev = 7'o55; cmd_data = 36'o7070;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("abort_set_high", 64'(datao_set), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check("abort_strobes", 64'(strb), 64'b0000_0010);
        check("abort_ios", 64'(ios), 64'd0);
        check("abort_iob_out", 64'(iob_out), 64'd0);
        check("abort_cmd_ready", 64'(cmd_ready), 64'd0);
        power_seq();

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/iobus_master.md
Name: iobus_master

Overview:
- Processor-side initiator for the PDP-6 IO bus; drives the bus that peripheral responders such as the teletype decode.
- Accepts one command at a time from the CPU IO sequencer: DATAO, CONO, DATAI or CONI.
- Produces device select, output data and the timed clear/set/read strobes; returns the sampled bus data for reads.
- Also generates power-on and IO reset, and priority-encodes the seven PI request lines.

Parameters:
- SETUP_CYC, 2, cycles ios/iob_out are stable before the first strobe
- CLR_CYC, 4, width of datao_clear/cono_clear
- GAP_CYC, 2, all-strobes-low cycles between clear and set
- SET_CYC, 4, width of datao_set/cono_set
- RD_CYC, 4, width of iob_fm_datai/iob_fm_status
- HOLD_CYC, 2, cycles ios/iob_out are held after the last strobe
- RST_CYC, 8, width of iob_reset
- PWR_CYC, 16, cycles iob_poweron stays low after reset release

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block idle; command accepted when valid&ready
- cmd_op  in  2  0=DATAO 1=CONO 2=DATAI 3=CONI
- cmd_dev  in  7  device number, bus bits [3:9]
- cmd_data  in  36  output word [0:35]
- rsp_valid  out  1  one-cycle pulse, read data valid
- rsp_data  out  36  sampled word [0:35]
- io_reset_req  in  1  request an IO bus reset
- pi_mask  in  7  channel enables [1:7]
- pi_level  out  3  highest-priority active enabled channel, 0 = none
- iobus_ios  out  7  [3:9] device select
- iobus_iob_out  out  36  data to devices
- iobus_iob_in  in  36  wired-OR data from devices
- iobus_pi_req  in  7  [1:7] from devices
- iobus_datao_clear, iobus_datao_set, iobus_cono_clear, iobus_cono_set, iobus_iob_fm_datai, iobus_iob_fm_status, iobus_iob_reset, iobus_iob_poweron  out  1 each

Behaviour:
- Reset (asynchronous, active-low) values:
  - All strobes 0, ios 0, iob_out 0, rsp 0, pi_level 0, cmd_ready 0.
  - iob_poweron 0; iob_reset 1.
  - State PWR, counter 0.
- Counter: 8-bit down counter; each timed state lasts exactly its parameter, reloaded on entry.
- States:
  - PWR: poweron=0, iob_reset=1. After PWR_CYC: poweron=1, go to RST.
  - RST: iob_reset=1 for RST_CYC, then IDLE.
  - IDLE: cmd_ready=1. Pending reset is taken before a command. Otherwise, on accept, latch op/dev/data, drive ios/iob_out, go to SETUP.
  - SETUP: after SETUP_CYC, go to CLR for ops 0/1, READ for ops 2/3.
  - CLR: datao_clear (op0) or cono_clear (op1) high for CLR_CYC.
  - GAP: all strobes low for GAP_CYC.
  - SET: datao_set or cono_set high for SET_CYC.
  - READ: iob_fm_datai (op2) or iob_fm_status (op3) high for RD_CYC. iob_in is sampled on the last READ cycle.
  - HOLD: HOLD_CYC. rsp_valid pulses on the first HOLD cycle for reads only. Then ios/iob_out return to 0 and the block goes to IDLE.
- Latency (defaults, counted from the accept edge):
  - DATAO/CONO: 14 busy cycles; cmd_ready rises on cycle 15.
  - DATAI/CONI: rsp_valid on cycle 7; ready on cycle 9.
- At most one strobe is high in any cycle. Each strobe is a single contiguous high run, preceded by at least one low cycle, so responder edge detectors fire exactly once.
- io_reset_req sets a sticky pending flag.
  - It never aborts an operation in progress.
  - The flag is cleared on entry to RST.
  - Requests that arrive during RST do not re-arm the flag.
- cmd_valid during busy is ignored; there is no queue. The source holds the command until ready.
- pi_req passes through a 2-flop synchronizer and is ANDed with pi_mask. pi_level is the lowest-numbered active channel (1 is highest), registered, 2-cycle latency.
- rsp_data holds its value until the next read completes.

Test Plan:
- Reset release -> poweron low for 16 cycles, then high; iob_reset high through PWR+RST (24 cycles); cmd_ready rises on cycle 25.
- DATAO dev 7'b0010100, data 0o101 -> ios=0010100 and iob_out=0o101 for 14 cycles; datao_clear high on cycles 3-6, datao_set high on cycles 9-12; no cono strobes.
- CONI dev 7'b0010100 with model returning 0o1257 while fm_status is high -> fm_status high on cycles 3-6; rsp_valid on cycle 7 with rsp_data=0o1257.
- io_reset_req pulsed mid-CONO -> CONO completes unaltered, then iob_reset is high for 8 cycles before cmd_ready rises.
- pi_req=7'b0011000 (channels 3,4), mask all ones -> pi_level=3 after 2 cycles; with channel 3 masked -> pi_level=4; with mask 0 -> 0.
- Assert reset low mid-DATAO set phase -> all strobes drop immediately (asynchronously) and the PWR sequence restarts.
